// File: rtl/washer_plant_model.sv
// Behavioural plant model of a washing machine: drum water level and
// temperature, door latch with engage/release delay, door sensor and soap tray.
// Consumes the controller's actuator commands and returns sensor feedback.
module washer_plant_model #(
  parameter int unsigned LEVEL_W        = 8,
  parameter int unsigned FILL_RATE      = 4,
  parameter int unsigned DRAIN_RATE     = 8,
  parameter int unsigned LEVEL_FULL     = 200,
  parameter int unsigned SPIN_MAX_LEVEL = 16,
  parameter int unsigned AMBIENT        = 20,
  parameter int unsigned TEMP_HOT_MAX   = 60,
  parameter int unsigned HOT_THRESH     = 40,
  parameter int unsigned LOCK_DLY       = 4,
  parameter int unsigned SOAP_DLY       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               power,
  input  logic               valve_in_cold,
  input  logic               valve_in_hot,
  input  logic               valve_out,
  input  logic [1:0]         motor,
  input  logic               soap_in,
  input  logic               lockDoor,
  input  logic               door_open_req,
  input  logic               door_close_req,
  input  logic               soap_load,
  output logic               doorclosed,
  output logic               door_locked,
  output logic               soap,
  output logic [LEVEL_W-1:0] water_level,
  output logic               water_full,
  output logic               water_empty,
  output logic [6:0]         temp,
  output logic               water_hot,
  output logic [3:0]         fault
);

  localparam int unsigned TEMP_W  = 7;
  localparam int unsigned SUM_W   = LEVEL_W + 2;
  localparam int unsigned LOCK_CW = (LOCK_DLY > 1) ? $clog2(LOCK_DLY + 1) : 1;
  localparam int unsigned SOAP_CW = (SOAP_DLY > 1) ? $clog2(SOAP_DLY + 1) : 1;

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_LOCKING   = 2'd1,
    ST_LOCKED    = 2'd2,
    ST_UNLOCKING = 2'd3
  } lock_state_t;

  lock_state_t          lock_q,        lock_nxt;
  logic [LOCK_CW-1:0]   lock_cnt_q,    lock_cnt_nxt;
  logic [LEVEL_W-1:0]   level_q,       level_nxt;
  logic [TEMP_W-1:0]    temp_q,        temp_nxt;
  logic                 doorclosed_q,  doorclosed_nxt;
  logic                 soap_q,        soap_nxt;
  logic                 soap_act_q,    soap_act_nxt;
  logic [SOAP_CW-1:0]   soap_cnt_q,    soap_cnt_nxt;
  logic                 soap_in_prev_q, soap_in_prev_nxt;
  logic [3:0]           fault_q,       fault_nxt;

  logic [SUM_W-1:0]        inflow;
  logic [SUM_W-1:0]        outflow;
  logic signed [SUM_W-1:0] sum;
  logic                    overflow_c;

  // Output decode from registered state
  assign door_locked = (lock_q == ST_LOCKED) || (lock_q == ST_UNLOCKING);
  assign doorclosed  = doorclosed_q;
  assign soap        = soap_q;
  assign water_level = level_q;
  assign temp        = temp_q;
  assign fault       = fault_q;
  assign water_full  = (level_q >= LEVEL_W'(LEVEL_FULL));
  assign water_empty = (level_q == '0);
  assign water_hot   = (temp_q >= TEMP_W'(HOT_THRESH));

  // Water level: netted inflow/outflow with clamping at both ends
  always_comb begin
    inflow     = '0;
    outflow    = '0;
    sum        = '0;
    level_nxt  = level_q;
    overflow_c = 1'b0;
    if (power) begin
      if (doorclosed_q) begin
        if (valve_in_cold) inflow = inflow + SUM_W'(FILL_RATE);
        if (valve_in_hot)  inflow = inflow + SUM_W'(FILL_RATE);
      end
      if (valve_out) outflow = SUM_W'(DRAIN_RATE);
      sum = $signed({2'b00, level_q} + inflow - outflow);
      if (sum[SUM_W-1]) begin
        level_nxt = '0;
      end else if (sum[SUM_W-2:LEVEL_W] != '0) begin
        level_nxt  = '1;
        overflow_c = 1'b1;
      end else begin
        level_nxt = sum[LEVEL_W-1:0];
      end
    end
  end

  // Temperature: ambient when empty, hot inlet heats, cold inlet cools
  always_comb begin
    temp_nxt = temp_q;
    if (power) begin
      if (level_nxt == '0) begin
        temp_nxt = TEMP_W'(AMBIENT);
      end else if (valve_in_hot) begin
        if (temp_q < TEMP_W'(TEMP_HOT_MAX)) temp_nxt = temp_q + TEMP_W'(1);
      end else if (valve_in_cold && (temp_q > TEMP_W'(AMBIENT))) begin
        temp_nxt = temp_q - TEMP_W'(1);
      end
    end
  end

  // Latch FSM next state with engage/release delay counter
  always_comb begin
    lock_nxt     = lock_q;
    lock_cnt_nxt = lock_cnt_q;
    if (power) begin
      case (lock_q)
        ST_UNLOCKED: begin
          if (lockDoor && doorclosed_q) begin
            if (LOCK_DLY <= 1) begin
              lock_nxt = ST_LOCKED;
            end else begin
              lock_nxt     = ST_LOCKING;
              lock_cnt_nxt = LOCK_CW'(1);
            end
          end
        end
        ST_LOCKING: begin
          if (!lockDoor) begin
            lock_nxt     = ST_UNLOCKED;
            lock_cnt_nxt = '0;
          end else if (lock_cnt_q >= LOCK_CW'(LOCK_DLY - 1)) begin
            lock_nxt     = ST_LOCKED;
            lock_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt_q + LOCK_CW'(1);
          end
        end
        ST_LOCKED: begin
          if (!lockDoor && water_empty && (motor == 2'b00)) begin
            if (LOCK_DLY <= 1) begin
              lock_nxt = ST_UNLOCKED;
            end else begin
              lock_nxt     = ST_UNLOCKING;
              lock_cnt_nxt = LOCK_CW'(1);
            end
          end
        end
        ST_UNLOCKING: begin
          if (lockDoor) begin
            lock_nxt     = ST_LOCKED;
            lock_cnt_nxt = '0;
          end else if (lock_cnt_q >= LOCK_CW'(LOCK_DLY - 1)) begin
            lock_nxt     = ST_UNLOCKED;
            lock_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt_q + LOCK_CW'(1);
          end
        end
        default: begin
          lock_nxt     = ST_UNLOCKED;
          lock_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Door sensor: user pulses work without power, open blocked by the latch
  always_comb begin
    doorclosed_nxt = doorclosed_q;
    if (door_close_req) begin
      doorclosed_nxt = 1'b1;
    end else if (door_open_req && !door_locked) begin
      doorclosed_nxt = 1'b0;
    end
  end

  // Soap tray: dispense countdown on soap_in rise, refill cancels it
  always_comb begin
    soap_nxt         = soap_q;
    soap_act_nxt     = soap_act_q;
    soap_cnt_nxt     = soap_cnt_q;
    soap_in_prev_nxt = soap_in_prev_q;
    if (power) begin
      soap_in_prev_nxt = soap_in;
      if (soap_act_q) begin
        if (soap_cnt_q >= SOAP_CW'(SOAP_DLY - 1)) begin
          soap_nxt     = 1'b0;
          soap_act_nxt = 1'b0;
          soap_cnt_nxt = '0;
        end else begin
          soap_cnt_nxt = soap_cnt_q + SOAP_CW'(1);
        end
      end else if (soap_in && !soap_in_prev_q && soap_q) begin
        if (SOAP_DLY <= 1) begin
          soap_nxt = 1'b0;
        end else begin
          soap_act_nxt = 1'b1;
          soap_cnt_nxt = SOAP_CW'(1);
        end
      end
    end
    if (soap_load) begin
      soap_nxt     = 1'b1;
      soap_act_nxt = 1'b0;
      soap_cnt_nxt = '0;
    end
  end

  // Sticky fault flags, raised only while powered
  always_comb begin
    fault_nxt = fault_q;
    if (power) begin
      if (overflow_c)                                         fault_nxt[0] = 1'b1;
      if (motor == 2'b11)                                     fault_nxt[1] = 1'b1;
      if ((motor != 2'b00) && !door_locked)                   fault_nxt[2] = 1'b1;
      if ((motor == 2'b10) && (level_q > LEVEL_W'(SPIN_MAX_LEVEL))) fault_nxt[3] = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q         <= ST_UNLOCKED;
      lock_cnt_q     <= '0;
      level_q        <= '0;
      temp_q         <= TEMP_W'(AMBIENT);
      doorclosed_q   <= 1'b1;
      soap_q         <= 1'b0;
      soap_act_q     <= 1'b0;
      soap_cnt_q     <= '0;
      soap_in_prev_q <= 1'b0;
      fault_q        <= '0;
    end else begin
      lock_q         <= lock_nxt;
      lock_cnt_q     <= lock_cnt_nxt;
      level_q        <= level_nxt;
      temp_q         <= temp_nxt;
      doorclosed_q   <= doorclosed_nxt;
      soap_q         <= soap_nxt;
      soap_act_q     <= soap_act_nxt;
      soap_cnt_q     <= soap_cnt_nxt;
      soap_in_prev_q <= soap_in_prev_nxt;
      fault_q        <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_washer_plant_model.sv
// Bench for washer_plant_model: directed table, hand sequences for latch,
// soap, faults and power, then randomized traffic against a reference model.
module tb_washer_plant_model;

  localparam int FILL = 4, DRAIN = 8, FULL = 200, SPIN_MAX = 16, AMB = 20;
  localparam int TMAX = 60, HOT = 40, LOCK_DLY = 4, SOAP_DLY = 3, LMAX = 255;

  logic       clk = 1'b0;
  logic       rst, power, valve_in_cold, valve_in_hot, valve_out;
  logic [1:0] motor;
  logic       soap_in, lockDoor, door_open_req, door_close_req, soap_load;
  logic       doorclosed, door_locked, soap, water_full, water_empty, water_hot;
  logic [7:0] water_level;
  logic [6:0] temp;
  logic [3:0] fault;

  washer_plant_model dut (
    .clk(clk), .rst(rst), .power(power),
    .valve_in_cold(valve_in_cold), .valve_in_hot(valve_in_hot), .valve_out(valve_out),
    .motor(motor), .soap_in(soap_in), .lockDoor(lockDoor),
    .door_open_req(door_open_req), .door_close_req(door_close_req), .soap_load(soap_load),
    .doorclosed(doorclosed), .door_locked(door_locked), .soap(soap),
    .water_level(water_level), .water_full(water_full), .water_empty(water_empty),
    .temp(temp), .water_hot(water_hot), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit model_on = 1'b0;

  // Reference model state, plain integers
  int m_lvl, m_temp, m_closed, m_locked, m_lpend, m_soap, m_spend, m_prev_si, m_fault;

  typedef struct {
    string name;
    int    cycles;
    bit    cold, hot, drain;
    int    level, tmp;
    bit    full, empty, hotf;
    int    flt;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_inputs();
    power = 1'b1; valve_in_cold = 1'b0; valve_in_hot = 1'b0; valve_out = 1'b0;
    motor = 2'b00; soap_in = 1'b0; lockDoor = 1'b0;
    door_open_req = 1'b0; door_close_req = 1'b0; soap_load = 1'b0;
  endtask

  task automatic model_reset();
    m_lvl = 0; m_temp = AMB; m_closed = 1; m_locked = 0; m_lpend = 0;
    m_soap = 0; m_spend = 0; m_prev_si = 0; m_fault = 0;
  endtask

  // One clock of plant behaviour computed from the rules directly
  task automatic model_step();
    int n_lvl, n_temp, n_closed, n_locked, n_lpend, n_soap, n_spend, n_prev, n_fault;
    int flow;
    if (rst) begin
      model_reset();
      return;
    end
    n_lvl = m_lvl; n_temp = m_temp; n_locked = m_locked; n_lpend = m_lpend;
    n_soap = m_soap; n_spend = m_spend; n_prev = m_prev_si; n_fault = m_fault;
    n_closed = m_closed;
    if (door_close_req) n_closed = 1;
    else if (door_open_req && m_locked == 0) n_closed = 0;
    if (power) begin
      flow = (m_closed != 0) ? FILL * (int'(valve_in_cold) + int'(valve_in_hot)) : 0;
      if (valve_out) flow -= DRAIN;
      n_lvl = m_lvl + flow;
      if (n_lvl < 0) n_lvl = 0;
      if (n_lvl > LMAX) begin n_lvl = LMAX; n_fault |= 1; end
      if (n_lvl == 0) n_temp = AMB;
      else if (valve_in_hot) n_temp = (m_temp + 1 > TMAX) ? TMAX : m_temp + 1;
      else if (valve_in_cold && m_temp > AMB) n_temp = m_temp - 1;
      if (motor == 2'b11) n_fault |= 2;
      if (motor != 2'b00 && m_locked == 0) n_fault |= 4;
      if (motor == 2'b10 && m_lvl > SPIN_MAX) n_fault |= 8;
      if (m_locked == 0) begin
        if (m_lpend > 0) begin
          if (!lockDoor) n_lpend = 0;
          else begin n_lpend = m_lpend - 1; if (n_lpend == 0) n_locked = 1; end
        end else if (lockDoor && m_closed != 0) begin
          n_lpend = LOCK_DLY - 1;
          if (n_lpend == 0) n_locked = 1;
        end
      end else begin
        if (m_lpend > 0) begin
          if (lockDoor) n_lpend = 0;
          else begin n_lpend = m_lpend - 1; if (n_lpend == 0) n_locked = 0; end
        end else if (!lockDoor && m_lvl == 0 && motor == 2'b00) begin
          n_lpend = LOCK_DLY - 1;
          if (n_lpend == 0) n_locked = 0;
        end
      end
      if (m_spend > 0) begin
        n_spend = m_spend - 1;
        if (n_spend == 0) n_soap = 0;
      end else if (soap_in && m_prev_si == 0 && m_soap != 0) begin
        n_spend = SOAP_DLY - 1;
        if (n_spend == 0) n_soap = 0;
      end
      n_prev = int'(soap_in);
    end
    if (soap_load) begin n_soap = 1; n_spend = 0; end
    m_lvl = n_lvl; m_temp = n_temp; m_closed = n_closed; m_locked = n_locked;
    m_lpend = n_lpend; m_soap = n_soap; m_spend = n_spend; m_prev_si = n_prev;
    m_fault = n_fault;
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_level"},  int'(water_level), 0);
    check({tag, "_temp"},   int'(temp), AMB);
    check({tag, "_closed"}, int'(doorclosed), 1);
    check({tag, "_locked"}, int'(door_locked), 0);
    check({tag, "_soap"},   int'(soap), 0);
    check({tag, "_fault"},  int'(fault), 0);
    check({tag, "_empty"},  int'(water_empty), 1);
    check({tag, "_full"},   int'(water_full), 0);
    check({tag, "_hot"},    int'(water_hot), 0);
  endtask

  task automatic check_model(input int cyc);
    check($sformatf("rnd%0d_level", cyc),  int'(water_level), m_lvl);
    check($sformatf("rnd%0d_temp", cyc),   int'(temp), m_temp);
    check($sformatf("rnd%0d_closed", cyc), int'(doorclosed), m_closed);
    check($sformatf("rnd%0d_locked", cyc), int'(door_locked), m_locked);
    check($sformatf("rnd%0d_soap", cyc),   int'(soap), m_soap);
    check($sformatf("rnd%0d_fault", cyc),  int'(fault), m_fault);
    check($sformatf("rnd%0d_full", cyc),   int'(water_full), int'(m_lvl >= FULL));
    check($sformatf("rnd%0d_empty", cyc),  int'(water_empty), int'(m_lvl == 0));
    check($sformatf("rnd%0d_hot", cyc),    int'(water_hot), int'(m_temp >= HOT));
  endtask

  task automatic set_vec(input int i, input string n, input int c, input bit co, input bit ho,
                         input bit dr, input int lv, input int tp, input bit fu,
                         input bit em, input bit hf, input int fl);
    vecs[i].name = n; vecs[i].cycles = c; vecs[i].cold = co; vecs[i].hot = ho;
    vecs[i].drain = dr; vecs[i].level = lv; vecs[i].tmp = tp; vecs[i].full = fu;
    vecs[i].empty = em; vecs[i].hotf = hf; vecs[i].flt = fl;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // name, cycles, cold, hot, drain, level, temp, full, empty, hot, fault
    set_vec(0, "fill_cold49",  49, 1, 0, 0, 196, 20, 0, 0, 0, 0);
    set_vec(1, "fill_cold50",   1, 1, 0, 0, 200, 20, 1, 0, 0, 0);
    set_vec(2, "fill_both14",  14, 1, 1, 0, 255, 34, 1, 0, 0, 1);
    set_vec(3, "drain31",      31, 0, 0, 1,   7, 34, 0, 0, 0, 1);
    set_vec(4, "drain32",       1, 0, 0, 1,   0, 20, 0, 1, 0, 1);
    set_vec(5, "hot19",        19, 0, 1, 0,  76, 39, 0, 0, 0, 1);
    set_vec(6, "hot20",         1, 0, 1, 0,  80, 40, 0, 0, 1, 1);
    set_vec(7, "hot30",        10, 0, 1, 0, 120, 50, 0, 0, 1, 1);

    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    check_reset("reset");
    rst = 1'b0;

    // Directed water/temperature table
    for (int i = 0; i < 8; i++) begin
      valve_in_cold = vecs[i].cold; valve_in_hot = vecs[i].hot; valve_out = vecs[i].drain;
      repeat (vecs[i].cycles) tick();
      valve_in_cold = 1'b0; valve_in_hot = 1'b0; valve_out = 1'b0;
      check({vecs[i].name, "_level"}, int'(water_level), vecs[i].level);
      check({vecs[i].name, "_temp"},  int'(temp), vecs[i].tmp);
      check({vecs[i].name, "_full"},  int'(water_full), int'(vecs[i].full));
      check({vecs[i].name, "_empty"}, int'(water_empty), int'(vecs[i].empty));
      check({vecs[i].name, "_hot"},   int'(water_hot), int'(vecs[i].hotf));
      check({vecs[i].name, "_fault"}, int'(fault), vecs[i].flt);
    end

    // Latch engage, hold while wet, release once empty
    valve_out = 1'b1; repeat (14) tick(); valve_out = 1'b0;
    check("latch_level8", int'(water_level), 8);
    lockDoor = 1'b1;
    repeat (3) tick(); check("lock_pending", int'(door_locked), 0);
    tick();            check("lock_engaged", int'(door_locked), 1);
    lockDoor = 1'b0;
    repeat (6) tick(); check("lock_held_wet", int'(door_locked), 1);
    door_open_req = 1'b1; tick(); door_open_req = 1'b0;
    check("open_ignored", int'(doorclosed), 1);
    valve_out = 1'b1; tick(); valve_out = 1'b0;
    check("latch_drained", int'(water_level), 0);
    check("latch_still", int'(door_locked), 1);
    repeat (3) tick(); check("unlock_pending", int'(door_locked), 1);
    tick();            check("unlock_done", int'(door_locked), 0);
    door_open_req = 1'b1; tick(); door_open_req = 1'b0;
    check("door_opened", int'(doorclosed), 0);
    door_open_req = 1'b1; door_close_req = 1'b1; tick();
    door_open_req = 1'b0; door_close_req = 1'b0;
    check("close_wins", int'(doorclosed), 1);

    // Soap dispense, then refill during the countdown
    soap_load = 1'b1; tick(); soap_load = 1'b0;
    check("soap_loaded", int'(soap), 1);
    soap_in = 1'b1; tick(); soap_in = 1'b0;
    tick(); check("soap_counting", int'(soap), 1);
    tick(); check("soap_dispensed", int'(soap), 0);
    soap_load = 1'b1; tick(); soap_load = 1'b0;
    soap_in = 1'b1; tick(); soap_in = 1'b0;
    tick();
    soap_load = 1'b1; tick(); soap_load = 1'b0;
    check("soap_refill_edge", int'(soap), 1);
    repeat (4) tick(); check("soap_refill_kept", int'(soap), 1);

    rst = 1'b1; tick(); rst = 1'b0;
    check_reset("rst_mid");

    // Power off: actuators ignored, user door pulses honoured
    power = 1'b0; valve_in_cold = 1'b1; valve_in_hot = 1'b1; motor = 2'b11; lockDoor = 1'b1;
    repeat (5) tick();
    check("poff_level", int'(water_level), 0);
    check("poff_temp", int'(temp), AMB);
    check("poff_fault", int'(fault), 0);
    check("poff_locked", int'(door_locked), 0);
    door_open_req = 1'b1; tick(); door_open_req = 1'b0;
    check("poff_open", int'(doorclosed), 0);
    door_close_req = 1'b1; tick(); door_close_req = 1'b0;
    check("poff_close", int'(doorclosed), 1);
    clear_inputs();

    // Fault flags
    motor = 2'b01; tick(); motor = 2'b00;
    check("fault_unlocked", int'(fault), 4);
    valve_in_cold = 1'b1; repeat (10) tick(); valve_in_cold = 1'b0;
    check("fault_fill40", int'(water_level), 40);
    motor = 2'b10; tick(); motor = 2'b00;
    check("fault_spin", int'(fault), 12);
    motor = 2'b11; tick(); motor = 2'b00;
    check("fault_illegal", int'(fault), 14);
    power = 1'b0; valve_in_cold = 1'b1; valve_in_hot = 1'b1;
    repeat (5) tick();
    check("freeze_level", int'(water_level), 40);
    check("freeze_temp", int'(temp), AMB);
    clear_inputs();

    // Reset while locked and unpowered
    lockDoor = 1'b1; repeat (4) tick();
    check("pre_rst_locked", int'(door_locked), 1);
    power = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    check_reset("rst_locked");
    clear_inputs();

    // Randomized traffic against the reference model
    model_on = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    check_model(0);
    for (int c = 1; c <= 3000; c++) begin
      int r;
      rst            = ($urandom_range(0, 599) == 0);
      power          = ($urandom_range(0, 9) != 0);
      valve_in_cold  = ($urandom_range(0, 2) == 0);
      valve_in_hot   = ($urandom_range(0, 3) == 0);
      valve_out      = ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 49));
      motor          = (r == 0) ? 2'b11 : (r < 3) ? 2'b10 : (r < 6) ? 2'b01 : 2'b00;
      if ($urandom_range(0, 29) == 0) lockDoor = ~lockDoor;
      if ($urandom_range(0, 5) == 0)  soap_in = ~soap_in;
      soap_load      = ($urandom_range(0, 39) == 0);
      door_open_req  = ($urandom_range(0, 39) == 0);
      door_close_req = ($urandom_range(0, 39) == 0);
      tick();
      check_model(c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/washer_plant_model.md
Name: washer_plant_model

Overview:
- Synthesizable behavioural model of the washing-machine hardware: drum water, heater path, door latch and soap tray.
- Sits at the far end of the washing-machine controller interface. It consumes the controller's actuator commands (valves, motor, soap_in, lockDoor) and returns the sensor feedback the controller and its benches depend on (doorclosed, soap, water level and temperature, faults).
- Used for closed-loop simulation and for FPGA demo builds.

Parameters:
- LEVEL_W, 8, water level counter width.
- FILL_RATE, 4, level units added per cycle per open inlet valve.
- DRAIN_RATE, 8, level units removed per cycle while valve_out is open.
- LEVEL_FULL, 200, level at or above which water_full is asserted.
- SPIN_MAX_LEVEL, 16, maximum level allowed during spin.
- AMBIENT, 20, temperature at reset and when the drum is empty (°C).
- TEMP_HOT_MAX, 60, ceiling for heating by the hot inlet.
- HOT_THRESH, 40, temperature at or above which water_hot is asserted.
- LOCK_DLY, 4, latch engage/release delay in cycles.
- SOAP_DLY, 3, cycles from soap_in rise to tray empty.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- power  in  1  mains; 0 freezes plant state.
- valve_in_cold  in  1  cold inlet open.
- valve_in_hot  in  1  hot inlet open.
- valve_out  in  1  drain open.
- motor  in  2  00 off, 01 wash, 10 spin, 11 illegal.
- soap_in  in  1  dispense command.
- lockDoor  in  1  latch request.
- door_open_req  in  1  user pulls door, one-cycle pulse.
- door_close_req  in  1  user shuts door, one-cycle pulse.
- soap_load  in  1  user fills tray, one-cycle pulse.
- doorclosed  out  1  door shut sensor.
- door_locked  out  1  latch engaged.
- soap  out  1  tray contains soap.
- water_level  out  LEVEL_W  current level.
- water_full  out  1  water_level >= LEVEL_FULL.
- water_empty  out  1  water_level == 0.
- temp  out  7  water temperature.
- water_hot  out  1  temp >= HOT_THRESH.
- fault  out  4  sticky flags: [0] overflow, [1] illegal motor, [2] motor with door unlocked, [3] spin above SPIN_MAX_LEVEL.

Behaviour:
Reset values (rst=1):
- water_level=0, temp=AMBIENT, doorclosed=1, door_locked=0, soap=0, fault=0.
- Lock counter and soap counter cleared; latch FSM in UNLOCKED.

Power:
- When power=0, all registers hold their values. Actuator inputs are ignored and no faults are raised. User door/soap pulses are still honoured, subject to the lock rules below.

Water level (registered, one update per cycle while power=1):
- Inflow = FILL_RATE × (valve_in_cold + valve_in_hot); only counted when doorclosed=1.
- Outflow = DRAIN_RATE when valve_out=1.
- next = level + inflow − outflow, computed at LEVEL_W+2 bits signed.
- Result below 0 clamps to 0.
- Result above 2^LEVEL_W−1 clamps to max and sets fault[0].
- Inflow and outflow in the same cycle are netted.

Temperature:
- If next level == 0: temp = AMBIENT.
- Else if valve_in_hot=1: temp+1, saturating at TEMP_HOT_MAX.
- Else if valve_in_cold=1 and temp > AMBIENT: temp−1.
- Otherwise temp holds.

Latch FSM (UNLOCKED, LOCKING, LOCKED, UNLOCKING):
- UNLOCKED→LOCKING when lockDoor=1 and doorclosed=1.
- LOCKING counts LOCK_DLY cycles, then →LOCKED (door_locked=1). lockDoor dropping in LOCKING returns to UNLOCKED.
- LOCKED→UNLOCKING only when lockDoor=0, water_empty=1 and motor=00. Otherwise the latch stays held.
- UNLOCKING counts LOCK_DLY cycles, then →UNLOCKED. lockDoor rising in UNLOCKING returns to LOCKED.
- door_locked=1 in LOCKED and UNLOCKING.

Door:
- door_open_req clears doorclosed only when door_locked=0; otherwise it is ignored.
- door_close_req sets doorclosed.
- If both requests arrive in the same cycle, close wins.

Soap:
- soap_load sets soap.
- A rising edge of soap_in while soap=1 starts a SOAP_DLY countdown; at zero, soap is cleared.
- soap_load during the countdown cancels it and soap remains 1.

Faults:
- Evaluated only while power=1. Sticky; cleared only by rst.
- fault[1]: motor=11.
- fault[2]: motor≠00 with door_locked=0.
- fault[3]: motor=10 with water_level > SPIN_MAX_LEVEL.

Flags:
- water_full, water_empty and water_hot are combinational from the registered level and temp.

Reset mid-operation:
- Takes effect at the next edge regardless of power or latch state. All state returns to reset values.

Test Plan:
- Reset, power=1, cold valve only for 50 cycles → water_level=200, water_full rises on cycle 50; temp=20; no fault.
- Level 200, hot+cold open for 14 cycles → level clamps at 255 and fault[0]=1. Then drain only for 32 cycles → level=0, water_empty=1, temp=20.
- Level 0, hot only for 30 cycles → level=120, temp=50, water_hot=1 from cycle 20 onward.
- lockDoor=1 → door_locked=1 after 4 cycles. With lockDoor=0 and level=8, latch stays held. door_open_req is ignored while locked. Drain to 0 → door_locked=0 after 4 more cycles. door_open_req then gives doorclosed=0.
- soap_load, then soap_in pulse → soap=0 three cycles after the rise. Repeat with soap_load two cycles after soap_in → soap stays 1.
- motor=01 while unlocked → fault[2]. motor=10 at level 40 → fault[3]. motor=11 → fault[1]. power=0 with valves open → level frozen. rst → all outputs return to reset values.
